// File: rtl/mult_pkg.sv
// mult_pkg: shared types and sizing for the radix-4 Booth multiplier.
package mult_pkg;
  localparam int MULT_WIDTH = 32;
  localparam int ITERS = MULT_WIDTH / 2;
  localparam int CNT_W = $clog2(ITERS) + 1;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  typedef enum logic [2:0] {BOOTH_ZERO, BOOTH_POS1, BOOTH_POS2, BOOTH_NEG1, BOOTH_NEG2} booth_op_t;
  function automatic booth_op_t booth_decode(input logic [2:0] t);
    return (t == 3'b011) ? BOOTH_POS2 :
           (t == 3'b100) ? BOOTH_NEG2 :
           (t == 3'b001 || t == 3'b010) ? BOOTH_POS1 :
           (t == 3'b101 || t == 3'b110) ? BOOTH_NEG1 : BOOTH_ZERO;
  endfunction
endpackage

// File: rtl/booth_encoder.sv
// booth_encoder: recodes a multiplier triplet into a sign-extended partial product plus carry-in.
module booth_encoder
  import mult_pkg::*;
#(parameter int WIDTH = MULT_WIDTH) (
  input  logic [2:0]       triplet_i,
  input  logic [WIDTH-1:0] a_i,
  output logic [WIDTH+1:0] pp_o,
  output logic             cin_o
);
  booth_op_t op;
  logic [WIDTH+1:0] a1, a2, mag;
  logic neg;
  assign op = booth_decode(triplet_i);
  assign a1 = {{2{a_i[WIDTH-1]}}, a_i};
  assign a2 = {a_i[WIDTH-1], a_i, 1'b0};
  assign mag = (op == BOOTH_POS2 || op == BOOTH_NEG2) ? a2 : (op == BOOTH_ZERO) ? '0 : a1;
  assign neg = op == BOOTH_NEG1 || op == BOOTH_NEG2;
  // negation completes in the accumulator adder through cin_o
  assign pp_o = neg ? ~mag : mag;
  assign cin_o = neg;
endmodule

// File: rtl/booth_multiplier.sv
// booth_multiplier: sequential signed radix-4 Booth multiplier with overflow flag.
// Define MULT_HI_EN to expose the upper product half on product_hi.
module booth_multiplier
  import mult_pkg::*;
#(parameter int WIDTH = MULT_WIDTH) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             start,
  output logic [WIDTH-1:0] product,
  output logic             ready,
  output logic             exception
`ifdef MULT_HI_EN
  ,
  output logic [WIDTH-1:0] product_hi
`endif
);
  localparam int N = WIDTH / 2;
  localparam int CW = $clog2(N) + 1;
  localparam int PW = 2 * WIDTH + 3;
  state_t state_q;
  logic [CW-1:0] cnt_q;
  logic [WIDTH-1:0] a_q, product_q;
  logic [PW-1:0] p_q, p_d;
  logic [WIDTH+1:0] pp, sum;
  logic [2*WIDTH-1:0] full;
  logic [WIDTH:0] top_bits;
  logic cin, last, ready_q, exception_q;
`ifdef MULT_HI_EN
  logic [WIDTH-1:0] product_hi_q;
  assign product_hi = product_hi_q;
`endif
  booth_encoder #(.WIDTH(WIDTH)) u_enc (
    .triplet_i(p_q[2:0]),
    .a_i      (a_q),
    .pp_o     (pp),
    .cin_o    (cin)
  );
  assign sum = p_q[PW-1:WIDTH+1] + pp + {{(WIDTH+1){1'b0}}, cin};
  assign p_d = {{2{sum[WIDTH+1]}}, sum, p_q[WIDTH:2]};
  assign full = p_d[2*WIDTH:1];
  // fits in WIDTH signed bits only if the top WIDTH+1 bits are a pure sign extension
  assign top_bits = full[2*WIDTH-1:WIDTH-1];
  assign last = cnt_q == CW'(N - 1);
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      a_q <= '0;
      p_q <= '0;
      product_q <= '0;
      ready_q <= 1'b0;
      exception_q <= 1'b0;
`ifdef MULT_HI_EN
      product_hi_q <= '0;
`endif
    end else begin
      ready_q <= state_q == DONE;
      if (start) begin
        state_q <= BUSY;
        cnt_q <= '0;
        a_q <= A;
        p_q <= {{(WIDTH+2){1'b0}}, B, 1'b0};
      end else if (state_q == BUSY) begin
        p_q <= p_d;
        cnt_q <= cnt_q + CW'(1);
        if (last) begin
          state_q <= DONE;
          product_q <= full[WIDTH-1:0];
          exception_q <= !(&top_bits || ~|top_bits);
`ifdef MULT_HI_EN
          product_hi_q <= full[2*WIDTH-1:WIDTH];
`endif
        end
      end else if (state_q == DONE) begin
        state_q <= IDLE;
      end
    end
  end
  assign product = product_q;
  assign ready = ready_q;
  assign exception = exception_q;
endmodule

// File: tb/tb_booth_multiplier.sv
// tb_booth_multiplier: directed vector table, control-sequence checks and a 64-bit reference sweep.
module tb_booth_multiplier;
  import mult_pkg::*;
  localparam int W = 32;
  localparam int LAT = ITERS + 1;
  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] prod;
    logic [W-1:0] hi;
    logic         exc;
  } vec_t;
  logic clock = 1'b0;
  logic reset, start, ready, exception;
  logic [W-1:0] A, B, product;
`ifdef MULT_HI_EN
  logic [W-1:0] product_hi;
`endif
  int n_cmp = 0;
  int n_bad = 0;
  vec_t vecs[14];
  always #5 clock = ~clock;
  booth_multiplier #(.WIDTH(W)) dut (
    .clock    (clock),
    .reset    (reset),
    .A        (A),
    .B        (B),
    .start    (start),
    .product  (product),
    .ready    (ready),
    .exception(exception)
`ifdef MULT_HI_EN
    ,
    .product_hi(product_hi)
`endif
  );
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  task automatic pulse_start(input logic [W-1:0] a, input logic [W-1:0] b);
    A = a;
    B = b;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    A = ~a;
    B = b ^ 32'h5a5a_a5a5;
  endtask
  task automatic wait_ready(output int lat);
    lat = 0;
    while (!ready && lat < 40) begin
      @(posedge clock);
      #1;
      lat++;
    end
  endtask
  task automatic count_ready(input int cycles, output int seen);
    seen = 0;
    repeat (cycles) begin
      @(posedge clock);
      #1;
      if (ready) seen++;
    end
  endtask
  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] prod, input logic [W-1:0] hi, input logic exc);
    int lat;
    pulse_start(a, b);
    wait_ready(lat);
    check({name, " latency"}, 64'(lat), 64'(LAT));
    check({name, " product"}, 64'(product), 64'(prod));
    check({name, " exception"}, 64'(exception), 64'(exc));
`ifdef MULT_HI_EN
    check({name, " product_hi"}, 64'(product_hi), 64'(hi));
`else
    if (hi !== hi) $display("unreachable");
`endif
    @(posedge clock);
    #1;
    check({name, " ready one cycle"}, 64'(ready), 64'd0);
    check({name, " product held"}, 64'(product), 64'(prod));
    check({name, " exception held"}, 64'(exception), 64'(exc));
  endtask
  initial begin
    int lat, seen;
    longint full;
    logic [W-1:0] ra, rb;
    vecs[0]  = '{32'd3,         32'd4,         32'd12,        32'h0000_0000, 1'b0};
    vecs[1]  = '{32'hFFFF_FFF9, 32'd6,         32'hFFFF_FFD6, 32'hFFFF_FFFF, 1'b0};
    vecs[2]  = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b1};
    vecs[3]  = '{32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 32'h0000_0001, 1'b1};
    vecs[4]  = '{32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 32'h4000_0000, 1'b1};
    vecs[5]  = '{32'd0,         32'd12345,     32'd0,         32'h0000_0000, 1'b0};
    vecs[6]  = '{32'd12345,     32'd0,         32'd0,         32'h0000_0000, 1'b0};
    vecs[7]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,         32'h0000_0000, 1'b0};
    vecs[8]  = '{32'h7FFF_FFFF, 32'd2,         32'hFFFF_FFFE, 32'h0000_0000, 1'b1};
    vecs[9]  = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0001, 32'h3FFF_FFFF, 1'b1};
    vecs[10] = '{32'd100,       32'hFFFF_FF9C, 32'hFFFF_D8F0, 32'hFFFF_FFFF, 1'b0};
    vecs[11] = '{32'h4000_0000, 32'hFFFF_FFFE, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0};
    vecs[12] = '{32'h4000_0000, 32'd2,         32'h8000_0000, 32'h0000_0000, 1'b1};
    vecs[13] = '{32'h8000_0000, 32'd1,         32'h8000_0000, 32'hFFFF_FFFF, 1'b0};
    reset = 1'b1;
    start = 1'b0;
    A = '0;
    B = '0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    check("reset product", 64'(product), 64'd0);
    check("reset ready", 64'(ready), 64'd0);
    check("reset exception", 64'(exception), 64'd0);
`ifdef MULT_HI_EN
    check("reset product_hi", 64'(product_hi), 64'd0);
`endif
    for (int i = 0; i < 14; i++)
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].prod, vecs[i].hi, vecs[i].exc);
    // restart during BUSY: only the second operation may report
    pulse_start(32'd5, 32'd5);
    count_ready(7, seen);
    pulse_start(32'd2, 32'd3);
    wait_ready(lat);
    check("restart first ready", 64'(seen), 64'd0);
    check("restart latency", 64'(lat), 64'(LAT));
    check("restart product", 64'(product), 64'd6);
    count_ready(20, seen);
    check("restart no extra ready", 64'(seen), 64'd0);
    // start sampled in DONE: old ready still pulses, new op follows
    pulse_start(32'd7, 32'd8);
    repeat (ITERS) @(posedge clock);
    #1;
    check("done-start pre ready", 64'(ready), 64'd0);
    A = 32'd3;
    B = 32'hFFFF_FFFB;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    check("done-start old ready", 64'(ready), 64'd1);
    check("done-start old product", 64'(product), 64'd56);
    @(posedge clock);
    #1;
    wait_ready(lat);
    check("done-start new latency", 64'(lat + 1), 64'(LAT));
    check("done-start new product", 64'(product), 64'hFFFF_FFF1);
    // reset mid-operation clears outputs that were nonzero
    run_op("pre-reset", 32'h7FFF_FFFF, 32'd2, 32'hFFFF_FFFE, 32'h0, 1'b1);
    pulse_start(32'd9, 32'd9);
    repeat (9) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    count_ready(30, seen);
    check("midreset ready", 64'(seen), 64'd0);
    check("midreset product", 64'(product), 64'd0);
    check("midreset exception", 64'(exception), 64'd0);
    // reset and start together: reset wins
    A = 32'd5;
    B = 32'd5;
    reset = 1'b1;
    start = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    start = 1'b0;
    count_ready(25, seen);
    check("reset+start ready", 64'(seen), 64'd0);
    check("reset+start product", 64'(product), 64'd0);
    for (int i = 0; i < 200; i++) begin
      ra = (i % 4 == 0) ? W'($urandom_range(0, 300)) - 32'd150 : $urandom;
      rb = (i % 3 == 0) ? W'($urandom_range(0, 300)) - 32'd150 : $urandom;
      full = longint'($signed(ra)) * longint'($signed(rb));
      pulse_start(ra, rb);
      wait_ready(lat);
      check($sformatf("rand%0d latency", i), 64'(lat), 64'(LAT));
      check($sformatf("rand%0d product", i), 64'(product), 64'(full[31:0]));
      check($sformatf("rand%0d exception", i), 64'(exception),
            64'((full > longint'(32'sh7FFF_FFFF)) || (full < -longint'(64'h8000_0000))));
`ifdef MULT_HI_EN
      check($sformatf("rand%0d product_hi", i), 64'(product_hi), 64'(full[63:32]));
`endif
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
